// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-flow types and background-state encodings
// Purpose: state enum for the game flow FSM and the 2-bit bgState codes that
//          the background renderer decodes.
// Ports:   none (package).
package game_pkg;

    typedef enum logic [2:0] {
        WELCOME,
        PLAY,
        HIT_PAUSE,
        GAME_OVER,
        WIN
    } game_state_t;

    localparam logic [1:0] BG_WELCOME  = 2'b00;
    localparam logic [1:0] BG_PLAY     = 2'b01;
    localparam logic [1:0] BG_GAMEOVER = 2'b10;
    localparam logic [1:0] BG_WIN      = 2'b11;

    localparam int TIMER_W = 10;

    // The hit pause is still "play" from the renderer's point of view.
    function automatic logic [1:0] bg_of(game_state_t s);
        case (s)
            PLAY, HIT_PAUSE: bg_of = BG_PLAY;
            GAME_OVER:       bg_of = BG_GAMEOVER;
            WIN:             bg_of = BG_WIN;
            default:         bg_of = BG_WELCOME;
        endcase
    endfunction

endpackage

// File: rtl/game_state_ctrl_if.sv
// rtl/game_state_ctrl_if.sv - event inputs and display outputs of the game flow controller
// Purpose: bundles the frame/key/gameplay event inputs and the renderer-facing
//          outputs of game_state_ctrl.
// Ports:   master drives startOfFrame, startKey, playerHit, levelCleared, timeUp
//          and observes bgState, lives, level, levelStart, freeze; slave is the
//          controller side.
interface game_state_ctrl_if;
    logic       startOfFrame;
    logic       startKey;
    logic       playerHit;
    logic       levelCleared;
    logic       timeUp;
    logic [1:0] bgState;
    logic [2:0] lives;
    logic [2:0] level;
    logic       levelStart;
    logic       freeze;

    modport master (
        output startOfFrame, startKey, playerHit, levelCleared, timeUp,
        input  bgState, lives, level, levelStart, freeze
    );

    modport slave (
        input  startOfFrame, startKey, playerHit, levelCleared, timeUp,
        output bgState, lives, level, levelStart, freeze
    );
endinterface

// File: rtl/game_state_ctrl_frame_timer.sv
// rtl/game_state_ctrl_frame_timer.sv - saturating frame counter with terminal-count detect
// Purpose: counts enable pulses (video frames); done_o flags the enable pulse
//          that arrives while the count equals the terminal value.
// Ports:   clk, resetN (async active-low), clr_i (sync clear, wins over en_i),
//          en_i (count enable), tc_i (terminal count), done_o.
module frame_timer
    import game_pkg::*;
(
    input  logic               clk,
    input  logic               resetN,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [TIMER_W-1:0] tc_i,
    output logic               done_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {TIMER_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q == tc_i);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game flow FSM: welcome, play, hit pause, game over, win
// Purpose: sequences the game, tracks lives and level, pulses levelStart for
//          object spawners and freezes motion outside active play.
// Ports:   clk, resetN (async active-low), gs (slave): startOfFrame, startKey,
//          playerHit, levelCleared, timeUp in; bgState, lives, level,
//          levelStart, freeze out (all registered).
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int INIT_LIVES        = 3,
    parameter int NUM_LEVELS        = 4,
    parameter int HIT_PAUSE_FRAMES  = 60,
    parameter int END_SCREEN_FRAMES = 180
) (
    input  logic              clk,
    input  logic              resetN,
    game_state_ctrl_if.slave  gs
);

    game_state_t        state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [2:0]         level_q, level_d;
    logic [1:0]         bg_q;
    logic               freeze_q;
    logic               level_start_q;
    logic               ls_req;
    // Holds 1 once the key has been seen released; resetting it to 0 means a
    // key held through reset cannot start a game until released and pressed.
    logic               key_rel_q;
    logic               key_rise;
    logic               tmr_clr;
    logic               tmr_done;
    logic [TIMER_W-1:0] tmr_tc;

    assign key_rise = gs.startKey & key_rel_q;

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        ls_req  = 1'b0;
        case (state_q)
            WELCOME: begin
                if (key_rise) begin
                    state_d = PLAY;
                    lives_d = 3'(INIT_LIVES);
                    level_d = 3'd0;
                    ls_req  = 1'b1;
                end
            end
            PLAY: begin
                if (gs.levelCleared) begin
                    if (level_q == 3'(NUM_LEVELS - 1)) begin
                        state_d = WIN;
                    end else begin
                        level_d = level_q + 3'd1;
                        ls_req  = 1'b1;
                    end
                end else if (gs.playerHit || gs.timeUp) begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q > 3'd1) ? HIT_PAUSE : GAME_OVER;
                end
            end
            HIT_PAUSE: begin
                if (tmr_done) begin
                    state_d = PLAY;
                    ls_req  = 1'b1;
                end
            end
            GAME_OVER, WIN: begin
                if (key_rise || tmr_done) begin
                    state_d = WELCOME;
                end
            end
            default: state_d = WELCOME;
        endcase
    end

    // Counter only runs in the timed states and restarts on every state entry.
    assign tmr_clr = (state_d != state_q) || (state_q == WELCOME) || (state_q == PLAY);
    assign tmr_tc  = (state_q == HIT_PAUSE) ? TIMER_W'(HIT_PAUSE_FRAMES - 1)
                                            : TIMER_W'(END_SCREEN_FRAMES - 1);

    frame_timer u_frame_timer (
        .clk    (clk),
        .resetN (resetN),
        .clr_i  (tmr_clr),
        .en_i   (gs.startOfFrame),
        .tc_i   (tmr_tc),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= WELCOME;
            lives_q       <= 3'(INIT_LIVES);
            level_q       <= 3'd0;
            bg_q          <= BG_WELCOME;
            freeze_q      <= 1'b1;
            level_start_q <= 1'b0;
            key_rel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            bg_q          <= bg_of(state_d);
            freeze_q      <= (state_d != PLAY);
            // Back-to-back requests collapse so levelStart is never two cycles wide.
            level_start_q <= ls_req & ~level_start_q;
            key_rel_q     <= ~gs.startKey;
        end
    end

    assign gs.bgState    = bg_q;
    assign gs.lives      = lives_q;
    assign gs.level      = level_q;
    assign gs.levelStart = level_start_q;
    assign gs.freeze     = freeze_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

    localparam int IL = 3;
    localparam int NL = 4;
    localparam int HP = 60;
    localparam int ES = 180;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    game_state_ctrl_if gs ();

    game_state_ctrl #(
        .INIT_LIVES        (IL),
        .NUM_LEVELS        (NL),
        .HIT_PAUSE_FRAMES  (HP),
        .END_SCREEN_FRAMES (ES)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .gs     (gs)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ls_cnt   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: screen (0 welcome,1 play,2 over,3 win), a paused flag,
    // lives, level and frames elapsed on the current screen.
    int m_bg = 0, m_lives = IL, m_level = 0, m_frames = 0;
    bit m_pause = 0, m_ls = 0, m_freeze = 1, m_key_prev = 1;

    task automatic model_step();
        bit rise;
        bit want_ls;
        rise       = gs.startKey && !m_key_prev;
        m_key_prev = gs.startKey;
        want_ls    = 0;
        if (m_bg == 0) begin
            if (rise) begin
                m_bg = 1; m_pause = 0; m_lives = IL; m_level = 0; want_ls = 1;
            end
        end else if (m_bg == 1 && !m_pause) begin
            if (gs.levelCleared) begin
                if (m_level == NL - 1) begin m_bg = 3; m_frames = 0; end
                else begin m_level++; want_ls = 1; end
            end else if (gs.playerHit || gs.timeUp) begin
                m_lives--;
                m_frames = 0;
                if (m_lives == 0) m_bg = 2;
                else m_pause = 1;
            end
        end else if (m_bg == 1) begin
            if (gs.startOfFrame) begin
                m_frames++;
                if (m_frames == HP) begin m_pause = 0; want_ls = 1; end
            end
        end else begin
            if (rise) m_bg = 0;
            else if (gs.startOfFrame) begin
                m_frames++;
                if (m_frames == ES) m_bg = 0;
            end
        end
        m_ls     = want_ls && !m_ls;
        m_freeze = !(m_bg == 1 && !m_pause);
    endtask

    initial forever begin
        @(posedge clk or negedge resetN);
        if (!resetN) begin
            m_bg = 0; m_pause = 0; m_lives = IL; m_level = 0; m_frames = 0;
            m_ls = 0; m_freeze = 1; m_key_prev = 1;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("bgState", int'(gs.bgState), m_bg);
            chk("lives", int'(gs.lives), m_lives);
            chk("level", int'(gs.level), m_level);
            chk("levelStart", int'(gs.levelStart), int'(m_ls));
            chk("freeze", int'(gs.freeze), int'(m_freeze));
            if (gs.levelStart) ls_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            gs.startOfFrame = 1'b1; tick();
            gs.startOfFrame = 1'b0; tick();
        end
    endtask

    task automatic press();
        gs.startKey = 1'b0; tick();
        gs.startKey = 1'b1; tick();
    endtask

    task automatic hit(input bit ph, input bit tu, input bit lc);
        gs.playerHit = ph; gs.timeUp = tu; gs.levelCleared = lc;
        tick();
        gs.playerHit = 0; gs.timeUp = 0; gs.levelCleared = 0;
    endtask

    int ls_before;

    initial begin
        gs.startOfFrame = 0; gs.startKey = 1; gs.playerHit = 0;
        gs.levelCleared = 0; gs.timeUp = 0;
        repeat (3) tick();
        chk("rst_bg", int'(gs.bgState), 0);
        chk("rst_lives", int'(gs.lives), 3);
        chk("rst_level", int'(gs.level), 0);
        chk("rst_ls", int'(gs.levelStart), 0);
        chk("rst_freeze", int'(gs.freeze), 1);
        cmp_en = 1'b1;
        resetN = 1'b1;
        repeat (4) tick();
        chk("held_key_no_start", int'(gs.bgState), 0);

        press();
        chk("start_bg", int'(gs.bgState), 1);
        chk("start_ls", int'(gs.levelStart), 1);
        chk("start_lives", int'(gs.lives), 3);
        chk("start_freeze", int'(gs.freeze), 0);
        tick();
        chk("start_ls_one_cycle", int'(gs.levelStart), 0);

        hit(1, 0, 0);
        chk("hit1_bg", int'(gs.bgState), 1);
        chk("hit1_freeze", int'(gs.freeze), 1);
        chk("hit1_lives", int'(gs.lives), 2);
        frames(HP - 1);
        chk("pause_59_freeze", int'(gs.freeze), 1);
        gs.startOfFrame = 1'b1; tick(); gs.startOfFrame = 1'b0;
        chk("pause_60_freeze", int'(gs.freeze), 0);
        chk("pause_60_ls", int'(gs.levelStart), 1);
        tick();

        hit(1, 0, 0);
        chk("hit2_lives", int'(gs.lives), 1);
        frames(HP);
        hit(1, 0, 0);
        chk("hit3_lives", int'(gs.lives), 0);
        chk("hit3_bg", int'(gs.bgState), 2);
        frames(ES - 1);
        chk("over_179_bg", int'(gs.bgState), 2);
        frames(1);
        chk("over_180_bg", int'(gs.bgState), 0);
        chk("over_exit_lives_held", int'(gs.lives), 0);

        press();
        chk("game2_lives", int'(gs.lives), 3);
        tick();
        for (int i = 1; i < NL; i++) begin
            hit(0, 0, 1);
            chk("lvl_level", int'(gs.level), i);
            chk("lvl_ls", int'(gs.levelStart), 1);
            tick();
        end
        hit(0, 0, 1);
        chk("win_bg", int'(gs.bgState), 3);
        chk("win_lives", int'(gs.lives), 3);
        chk("win_level", int'(gs.level), 3);
        tick();
        press();
        chk("win_key_exit_bg", int'(gs.bgState), 0);
        chk("win_key_exit_ls", int'(gs.levelStart), 0);

        press();
        chk("game3_lives", int'(gs.lives), 3);
        chk("game3_level", int'(gs.level), 0);
        tick();
        hit(1, 0, 0);
        frames(HP);
        hit(1, 1, 0);
        chk("double_hit_lives", int'(gs.lives), 1);
        chk("double_hit_freeze", int'(gs.freeze), 1);
        frames(HP);
        tick();
        hit(1, 1, 1);
        chk("combo_level", int'(gs.level), 1);
        chk("combo_lives", int'(gs.lives), 1);
        chk("combo_freeze", int'(gs.freeze), 0);
        chk("combo_bg", int'(gs.bgState), 1);
        tick();

        hit(1, 0, 0);
        chk("last_hit_bg", int'(gs.bgState), 2);
        frames(10);
        ls_before = ls_cnt;
        press();
        chk("over_key_bg", int'(gs.bgState), 0);
        tick();
        chk("over_key_no_ls", ls_cnt, ls_before);

        press();
        chk("game4_lives", int'(gs.lives), 3);
        chk("game4_bg", int'(gs.bgState), 1);
        tick();
        hit(1, 0, 0);
        frames(20);
        ls_before = ls_cnt;
        resetN = 1'b0;
        #1;
        chk("midreset_bg", int'(gs.bgState), 0);
        chk("midreset_lives", int'(gs.lives), 3);
        chk("midreset_freeze", int'(gs.freeze), 1);
        chk("midreset_ls", int'(gs.levelStart), 0);
        tick();
        tick();
        resetN = 1'b1;
        tick();
        tick();
        chk("postreset_bg", int'(gs.bgState), 0);
        chk("postreset_no_ls", ls_cnt, ls_before);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
